// File: rtl/sal_pkg.sv
// rtl/sal_pkg.sv - shared SAL types for the DRAM command arbiter
package sal_pkg;

    typedef logic [2:0]  dram_ba_t;
    typedef logic [15:0] dram_ra_t;
    typedef logic [9:0]  dram_ca_t;
    typedef logic [3:0]  axi_id_t;
    typedef logic [7:0]  axi_len_t;
    typedef logic [3:0]  t_cnt_t;

    typedef enum logic [2:0] {
        CMD_ACT = 3'd0,
        CMD_RD  = 3'd1,
        CMD_WR  = 3'd2,
        CMD_PRE = 3'd3,
        CMD_REF = 3'd4
    } cmd_type_t;

    // Arbitration classes in descending priority; RD and WR share CLS_CAS.
    typedef enum logic [2:0] {
        CLS_REF  = 3'd0,
        CLS_CAS  = 3'd1,
        CLS_ACT  = 3'd2,
        CLS_PRE  = 3'd3,
        CLS_NONE = 3'd4
    } arb_cls_t;

endpackage

// File: rtl/sal_timing_if.sv
// rtl/sal_timing_if.sv - inter-bank timing parameters (minus one) seen by the arbiter
interface TIMING_IF;
    import sal_pkg::*;

    t_cnt_t t_rrd_m1;
    t_cnt_t t_ccd_m1;
    t_cnt_t t_wtr_m1;
    t_cnt_t t_rtw_m1;

    modport MON (input t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1);
endinterface

// File: rtl/sal_rr_arbiter.sv
// rtl/sal_rr_arbiter.sv - one-hot bank selector for one command class
// SAL_CMD_ARB_RR_EN: rotating pointer; otherwise lowest index wins.
module sal_rr_arbiter #(
    parameter int NUM_BANKS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] i_req,
    input  logic                 i_adv,
    output logic [NUM_BANKS-1:0] o_gnt
);

`ifdef SAL_CMD_ARB_RR_EN
    localparam int PW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next;
    logic [PW-1:0] w_pos;
    logic          w_found;
    int            w_idx;

    always_comb begin
        o_gnt   = '0;
        w_next  = r_ptr;
        w_pos   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= NUM_BANKS) w_idx = w_idx - NUM_BANKS;
            w_pos = w_idx[PW-1:0];
            if (!w_found && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                w_found      = 1'b1;
                w_next       = (w_idx == NUM_BANKS - 1) ? '0 : w_pos + 1'b1;
            end
        end
    end

    // Pointer only moves when this class actually wins the shared bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= w_next;
        end
    end
`else
    logic w_found;
    logic w_unused_ok;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (!w_found && i_req[i]) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end

    assign w_unused_ok = &{1'b0, clk, rst_n, i_adv};
`endif

endmodule

// File: rtl/sal_cmd_arbiter.sv
// rtl/sal_cmd_arbiter.sv - per-bank DRAM command arbiter with inter-bank timing gates
// SAL_CMD_ARB_RR_EN selects round-robin within each class instead of fixed priority.
module sal_cmd_arbiter
    import sal_pkg::*;
#(
    parameter int NUM_BANKS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    TIMING_IF.MON                          timing_if,
    input  logic     [NUM_BANKS-1:0]       act_req,
    input  logic     [NUM_BANKS-1:0]       rd_req,
    input  logic     [NUM_BANKS-1:0]       wr_req,
    input  logic     [NUM_BANKS-1:0]       pre_req,
    input  logic     [NUM_BANKS-1:0]       ref_req,
    output logic     [NUM_BANKS-1:0]       act_gnt,
    output logic     [NUM_BANKS-1:0]       rd_gnt,
    output logic     [NUM_BANKS-1:0]       wr_gnt,
    output logic     [NUM_BANKS-1:0]       pre_gnt,
    output logic     [NUM_BANKS-1:0]       ref_gnt,
    input  dram_ra_t [NUM_BANKS-1:0]       req_ra,
    input  dram_ca_t [NUM_BANKS-1:0]       req_ca,
    input  axi_id_t  [NUM_BANKS-1:0]       req_id,
    input  axi_len_t [NUM_BANKS-1:0]       req_len,
    output logic                           cmd_valid,
    output cmd_type_t                      cmd_type,
    output dram_ba_t                       cmd_ba,
    output dram_ra_t                       cmd_ra,
    output dram_ca_t                       cmd_ca,
    output axi_id_t                        cmd_id,
    output axi_len_t                       cmd_len
);

    t_cnt_t r_rrd_cnt, r_ccd_cnt, r_wtr_cnt, r_rtw_cnt;

    logic w_act_ok, w_rd_ok, w_wr_ok;
    logic [NUM_BANKS-1:0] w_ref_v, w_rd_v, w_wr_v, w_act_v, w_pre_v, w_cas_v;
    logic [NUM_BANKS-1:0] w_ref_oh, w_cas_oh, w_act_oh, w_pre_oh, w_win_oh;
    arb_cls_t  w_sel;
    cmd_type_t w_win_type;
    dram_ba_t  w_win_ba;
    dram_ra_t  w_win_ra;
    dram_ca_t  w_win_ca;
    axi_id_t   w_win_id;
    axi_len_t  w_win_len;

    assign w_act_ok = (r_rrd_cnt == '0);
    assign w_rd_ok  = (r_ccd_cnt == '0) && (r_wtr_cnt == '0);
    assign w_wr_ok  = (r_ccd_cnt == '0) && (r_rtw_cnt == '0);

    // Each bank offers only its single best eligible command to the class pools.
    always_comb begin
        w_ref_v = '0;
        w_rd_v  = '0;
        w_wr_v  = '0;
        w_act_v = '0;
        w_pre_v = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (ref_req[b])                 w_ref_v[b] = 1'b1;
            else if (rd_req[b] && w_rd_ok)  w_rd_v[b]  = 1'b1;
            else if (wr_req[b] && w_wr_ok)  w_wr_v[b]  = 1'b1;
            else if (act_req[b] && w_act_ok) w_act_v[b] = 1'b1;
            else if (pre_req[b])            w_pre_v[b] = 1'b1;
        end
    end

    assign w_cas_v = w_rd_v | w_wr_v;

    always_comb begin
        w_sel = CLS_NONE;
        if (|w_ref_v)      w_sel = CLS_REF;
        else if (|w_cas_v) w_sel = CLS_CAS;
        else if (|w_act_v) w_sel = CLS_ACT;
        else if (|w_pre_v) w_sel = CLS_PRE;
    end

    sal_rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb_ref (
        .clk(clk), .rst_n(rst_n), .i_req(w_ref_v), .i_adv(w_sel == CLS_REF), .o_gnt(w_ref_oh));
    sal_rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb_cas (
        .clk(clk), .rst_n(rst_n), .i_req(w_cas_v), .i_adv(w_sel == CLS_CAS), .o_gnt(w_cas_oh));
    sal_rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb_act (
        .clk(clk), .rst_n(rst_n), .i_req(w_act_v), .i_adv(w_sel == CLS_ACT), .o_gnt(w_act_oh));
    sal_rr_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb_pre (
        .clk(clk), .rst_n(rst_n), .i_req(w_pre_v), .i_adv(w_sel == CLS_PRE), .o_gnt(w_pre_oh));

    assign ref_gnt = (rst_n && w_sel == CLS_REF) ? w_ref_oh : '0;
    assign rd_gnt  = (rst_n && w_sel == CLS_CAS) ? (w_cas_oh & w_rd_v) : '0;
    assign wr_gnt  = (rst_n && w_sel == CLS_CAS) ? (w_cas_oh & w_wr_v) : '0;
    assign act_gnt = (rst_n && w_sel == CLS_ACT) ? w_act_oh : '0;
    assign pre_gnt = (rst_n && w_sel == CLS_PRE) ? w_pre_oh : '0;
    assign w_win_oh = ref_gnt | rd_gnt | wr_gnt | act_gnt | pre_gnt;

    always_comb begin
        w_win_type = CMD_ACT;
        if (|ref_gnt)      w_win_type = CMD_REF;
        else if (|rd_gnt)  w_win_type = CMD_RD;
        else if (|wr_gnt)  w_win_type = CMD_WR;
        else if (|pre_gnt) w_win_type = CMD_PRE;
        w_win_ba  = '0;
        w_win_ra  = '0;
        w_win_ca  = '0;
        w_win_id  = '0;
        w_win_len = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_win_oh[b]) begin
                w_win_ba  = dram_ba_t'(b);
                w_win_ra  = req_ra[b];
                w_win_ca  = req_ca[b];
                w_win_id  = req_id[b];
                w_win_len = req_len[b];
            end
        end
    end

    // A grant reloads its counters; otherwise they drain to zero and stay there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrd_cnt <= '0;
            r_ccd_cnt <= '0;
            r_wtr_cnt <= '0;
            r_rtw_cnt <= '0;
        end else begin
            if (|act_gnt)                r_rrd_cnt <= timing_if.t_rrd_m1;
            else if (r_rrd_cnt != '0)    r_rrd_cnt <= r_rrd_cnt - 1'b1;
            if (|rd_gnt || |wr_gnt)      r_ccd_cnt <= timing_if.t_ccd_m1;
            else if (r_ccd_cnt != '0)    r_ccd_cnt <= r_ccd_cnt - 1'b1;
            if (|wr_gnt)                 r_wtr_cnt <= timing_if.t_wtr_m1;
            else if (r_wtr_cnt != '0)    r_wtr_cnt <= r_wtr_cnt - 1'b1;
            if (|rd_gnt)                 r_rtw_cnt <= timing_if.t_rtw_m1;
            else if (r_rtw_cnt != '0)    r_rtw_cnt <= r_rtw_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_ACT;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= |w_win_oh;
            if (|w_win_oh) begin
                cmd_type <= w_win_type;
                cmd_ba   <= w_win_ba;
                cmd_ra   <= w_win_ra;
                cmd_ca   <= w_win_ca;
                cmd_id   <= w_win_id;
                cmd_len  <= w_win_len;
            end
        end
    end

endmodule
